// File: rtl/tracer_center_seed_seq.sv
// Captures the centre stream into a register file, then hands each entry to the contour core as a seed.
// Latency: seed_valid rises 1 cycle after start or trace_done; seq_done 1 cycle after the final trace_done.
// Backpressure: seed held stable until seed_ready; next seed waits for trace_done. Option: TRACER_SKIP_EMPTY_EN.
module tracer_center_seed_seq #(
  parameter int DEPTH = 64
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     load_center,
  input  logic [7:0]               center_row,
  input  logic [8:0]               center_col,
  input  logic                     load_contour_start,
  output logic                     seed_valid,
  input  logic                     seed_ready,
  output logic [7:0]               seed_row,
  output logic [8:0]               seed_col,
  output logic [$clog2(DEPTH)-1:0] seed_index,
  input  logic                     trace_done,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic [$clog2(DEPTH):0]   seed_count,
  output logic                     overrun
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [PW-1:0] ONE  = PW'(1);

  typedef struct packed {
    logic [7:0] row;
    logic [8:0] col;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t          state_q, state_d;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            refill_q, refill_d;
  logic            wr_en;
  logic [IW-1:0]   wr_addr;
  entry_t          wr_dat;
  entry_t          rd_dat;
  logic            nxt_empty;
  logic            seq_done_d;
  logic            overrun_d;
  logic [PW-1:0]   seed_count_d;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    refill_d     = refill_q;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q[IW-1:0];
    wr_dat       = '{row: center_row, col: center_col};
    seed_count_d = seed_count;
    seq_done_d   = 1'b0;
    overrun_d    = overrun;
    unique case (state_q)
      ST_IDLE: begin
        // A fresh burst always restarts at entry 0; otherwise fill until saturated.
        if (load_center) begin
          if (refill_q) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_ptr_d = ONE;
            refill_d = 1'b0;
          end else if (wr_ptr_q != FULL) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
          end
        end
        if (load_contour_start) begin
          rd_ptr_d     = '0;
          seed_count_d = '0;
          overrun_d    = 1'b0;
          state_d      = (wr_ptr_d == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (load_center || load_contour_start) overrun_d = 1'b1;
        if (seed_valid && seed_ready) begin
          seed_count_d = seed_count + ONE;
          state_d      = ST_WAIT;
        end
`ifdef TRACER_SKIP_EMPTY_EN
        else if (!seed_valid) begin
          rd_ptr_d = rd_ptr_q + ONE;
          if (rd_ptr_d == wr_ptr_q) begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
          end
        end
`endif
      end
      ST_WAIT: begin
        if (load_center || load_contour_start) overrun_d = 1'b1;
        if (trace_done) begin
          rd_ptr_d = rd_ptr_q + ONE;
          if (rd_ptr_d == wr_ptr_q) begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        refill_d   = 1'b1;
        // An empty run reaches DONE without a final trace_done, so its pulse comes from here.
        seq_done_d = (wr_ptr_q == '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bypass covers a start arriving with the very first write of a burst.
  always_comb begin
    rd_dat = mem[rd_ptr_d[IW-1:0]];
    if (wr_en && (wr_addr == rd_ptr_d[IW-1:0])) rd_dat = wr_dat;
  end

`ifdef TRACER_SKIP_EMPTY_EN
  assign nxt_empty = (rd_dat == '0);
`else
  assign nxt_empty = 1'b0;
`endif

  always_ff @(posedge s_axi_aclk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      refill_q   <= 1'b1;
      seed_valid <= 1'b0;
      seed_row   <= '0;
      seed_col   <= '0;
      seed_index <= '0;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
      seed_count <= '0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      refill_q   <= refill_d;
      seed_valid <= (state_d == ST_ISSUE) && !nxt_empty;
      if (state_d == ST_ISSUE) begin
        seed_row   <= rd_dat.row;
        seed_col   <= rd_dat.col;
        seed_index <= rd_ptr_d[IW-1:0];
      end
      seq_busy   <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      seq_done   <= seq_done_d;
      seed_count <= seed_count_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: doc/tracer_center_seed_seq.md
# tracer_center_seed_seq

Downstream stage of the centre loader in the CImgTracer datapath. Captures the 64-entry centre stream (`load_center` qualified row/col words) into a local register file. On `load_contour_start` it walks the captured entries and hands each centre to the contour tracer core as a seed over a valid/ready handshake. It waits for the core's per-seed completion before issuing the next seed, then pulses `seq_done`.

## Interface
Parameters:
- `DEPTH`, 64, number of centre entries; the index width is 6 bits at the default.

Ports:
- `s_axi_aclk` in 1: clock.
- `s_axi_aresetn` in 1: asynchronous, active-low reset.
- `load_center` in 1: centre stream qualifier, high for one cycle per entry.
- `center_row` in 8: centre row, valid when `load_center` is high.
- `center_col` in 9: centre column, valid when `load_center` is high.
- `load_contour_start` in 1: single-cycle pulse that starts sequencing.
- `seed_valid` out 1: a seed is presented to the core.
- `seed_ready` in 1: the core accepts the seed.
- `seed_row` out 8: seed row.
- `seed_col` out 9: seed column.
- `seed_index` out 6: entry index of the current seed.
- `trace_done` in 1: single-cycle pulse from the core when the current seed's contour is finished.
- `seq_busy` out 1: high in ISSUE or WAIT.
- `seq_done` out 1: single-cycle pulse when sequencing ends.
- `seed_count` out 7: number of seeds accepted in the last run (0..64).
- `overrun` out 1: sticky flag; `load_center` or `load_contour_start` arrived while busy.

## Operation
- Capture:
  - In IDLE, each `load_center` cycle writes {row,col} to entry `wr_ptr`, then `wr_ptr` increments.
  - `wr_ptr` is 7 bits and saturates at 64; writes beyond 64 are dropped.
  - The first `load_center` after IDLE, or after a completed run, resets `wr_ptr` to 0 before the write, so each burst refills from entry 0.
- States:
  - IDLE: capture is active. On `load_contour_start`, go to ISSUE with `rd_ptr`=0 and `seed_count`=0. If `wr_ptr`==0, go straight to DONE.
  - ISSUE: `seed_valid`=1 with entry `rd_ptr` on the seed outputs. On `seed_valid && seed_ready`, increment `seed_count` and go to WAIT.
  - WAIT: on `trace_done`, increment `rd_ptr`. If `rd_ptr`+1 == `wr_ptr`, go to DONE; otherwise go to ISSUE.
  - DONE: pulse `seq_done` for one cycle, then return to IDLE.
- Seed outputs hold stable while `seed_valid` is high and not yet accepted. `seed_valid` never drops without acceptance.
- `trace_done` is ignored outside WAIT. A `trace_done` in the same cycle as acceptance in ISSUE is ignored.
- A `load_center` or `load_contour_start` in ISSUE or WAIT is ignored and sets `overrun`. `overrun` clears on the next `load_contour_start` that is accepted in IDLE.
- If `load_center` and `load_contour_start` occur in the same IDLE cycle, the write completes first. The run uses the updated `wr_ptr`.

## Timing
- Reset values: `seed_valid`=0, `seed_row`=0, `seed_col`=0, `seed_index`=0, `seq_busy`=0, `seq_done`=0, `seed_count`=0, `overrun`=0. State is IDLE and `wr_ptr`=0. Register-file contents are don't-care.
- Capture: an entry is readable 1 cycle after its `load_center` cycle. The upstream stream is 64 consecutive cycles followed by a `load_contour_start` pulse on the cycle after the last word.
- Start latency: `seed_valid` rises 1 cycle after `load_contour_start`.
- Next-seed latency: `seed_valid` rises 1 cycle after `trace_done` in WAIT.
- `seq_done` asserts 1 cycle after the final `trace_done`. With `wr_ptr`==0 it asserts 2 cycles after `load_contour_start`.
- All outputs are registered. No combinational path exists from `seed_ready` to `seed_valid`.
- Reset mid-run: immediate return to reset values. No `seq_done` is emitted and captured data is discarded logically (`wr_ptr`=0).

## Configuration
- `TRACER_SKIP_EMPTY_EN`:
  - Defined: in ISSUE, an entry with row==0 and col==0 is not presented. `rd_ptr` advances one entry per cycle with `seed_valid` low and `seed_count` unchanged. If the skipped entry is the last one, the block goes to DONE.
  - Undefined: every captured entry is issued, including (0,0).

## Test plan
- Basic run: stream 64 entries with row=i, col=2i, start, tie `seed_ready`=1, and return `trace_done` 3 cycles after each acceptance. Required: 64 seeds in index order with the matching row/col, `seed_count`=64, one `seq_done`.
- Backpressure: hold `seed_ready`=0 for 5 cycles on seed 7 (row 7, col 14). Required: `seed_valid` and outputs stable for all 5 cycles; exactly one acceptance.
- Short burst: 3 entries, then start. Required: seeds 0..2 only, `seed_count`=3. With 0 entries, `seq_done` 2 cycles after start and `seed_count`=0.
- Overrun: pulse `load_center` during WAIT. Required: `overrun`=1, stored entries unchanged, run completes normally. `overrun` clears on the next accepted start.
- Skip (macro defined): entries 1 and 63 set to (0,0) among 64. Required: 62 seeds with indices 1 and 63 absent, `seed_count`=62, `seq_done` after entry 62's `trace_done` plus the skip cycle.
- Reset mid-WAIT: assert `s_axi_aresetn`=0 during seed 10. Required: all outputs at reset values and no `seq_done`. A new 64-entry stream plus start runs from index 0.
